// File: rtl/axi4_pkg.sv
// axi4_pkg: AXI4 burst/size field widths and burst type encodings
package axi4_pkg;
  localparam int BURST_BITS = 2;
  localparam int SIZE_BITS = 3;
  localparam logic [BURST_BITS-1:0] BURST_FIXED = 2'd0;
  localparam logic [BURST_BITS-1:0] BURST_INCR = 2'd1;
  localparam logic [BURST_BITS-1:0] BURST_WRAP = 2'd2;
endpackage

// File: rtl/dmac_read_pkg.sv
// dmac_read_pkg: read-path aligner FSM state encoding
package dmac_read_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} rd_state_t;
endpackage

// File: rtl/dmac_byte_shifter.sv
// dmac_byte_shifter: shifts an R beat down by the byte offset and merges its low bytes above the residual
module dmac_byte_shifter #(
  parameter int DATA_WD = 32,
  localparam int STRB_WD = DATA_WD/8,
  localparam int OW = $clog2(STRB_WD)
) (
  input  logic [DATA_WD-1:0] beat,
  input  logic [DATA_WD-1:0] residual,
  input  logic [OW-1:0]      offset,
  output logic [DATA_WD-1:0] merged,
  output logic [DATA_WD-1:0] shifted,
  output logic [STRB_WD-1:0] strb
);
  logic [OW:0] cnt;
  always_comb begin
    cnt = (OW+1)'(STRB_WD) - {1'b0, offset};
    shifted = beat >> {offset, 3'b000};
    merged = residual | (beat << {cnt, 3'b000});
    strb = ~({STRB_WD{1'b1}} << cnt);
  end
endmodule

// File: rtl/dmac_read_data_aligner.sv
// dmac_read_data_aligner: repacks AXI R beats to a lane-0-aligned stream; DMAC_RD_ALIGN_RESP_EN adds r_resp/rd_data_err
module dmac_read_data_aligner
  import axi4_pkg::*;
  import dmac_read_pkg::*;
#(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  localparam int STRB_WD = DATA_WD/8,
  localparam int OW = $clog2(STRB_WD)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_cmd_valid,
  output logic                          rd_cmd_ready,
  input  logic [BURST_BITS-1:0]         rd_cmd_burst,
  input  logic [SIZE_BITS-1:0]          rd_cmd_size,
  input  logic [$clog2(ADDR_WD/8)-1:0]  rd_cmd_data_offset,
  input  logic                          r_valid,
  input  logic                          r_last,
  output logic                          r_ready,
  input  logic [DATA_WD-1:0]            r_data,
  output logic                          rd_data_valid,
  input  logic                          rd_data_ready,
  output logic [DATA_WD-1:0]            rd_data,
  output logic [STRB_WD-1:0]            rd_data_strb,
  output logic                          rd_data_last
`ifdef DMAC_RD_ALIGN_RESP_EN
  ,
  input  logic [1:0]                    r_resp,
  output logic                          rd_data_err
`endif
);
  rd_state_t state, nxt;
  logic [OW-1:0] off;
  logic [BURST_BITS-1:0] burst_q;
  logic [SIZE_BITS-1:0] size_q;
  logic seen, beat, pass, out_free, load, out_last, merge;
  logic [DATA_WD-1:0] res, merged, shifted, out_data;
  logic [STRB_WD-1:0] strb_part, out_strb;
  logic unused_ok;
  assign unused_ok = ^{size_q, rd_cmd_data_offset};
  dmac_byte_shifter #(.DATA_WD(DATA_WD)) u_shift (
    .beat(r_data), .residual(res), .offset(off),
    .merged(merged), .shifted(shifted), .strb(strb_part)
  );
  always_comb begin
    out_free = !rd_data_valid || rd_data_ready;
    pass = off == '0 || burst_q == BURST_FIXED;
    merge = !pass && seen;
    rd_cmd_ready = state == IDLE;
    r_ready = state == STREAM && out_free;
    beat = r_valid && r_ready;
    load = state == FLUSH ? out_free : beat && (pass || seen || r_last);
    out_data = state == FLUSH ? res : merge ? merged : shifted;
    out_strb = state == STREAM && merge ? '1 : strb_part;
    out_last = state == FLUSH || (r_last && !merge);
    nxt = state;
    if (state == IDLE && rd_cmd_valid) nxt = STREAM;
    if (state == FLUSH && out_free) nxt = IDLE;
    if (beat && r_last) nxt = merge ? FLUSH : IDLE;
  end
`ifdef DMAC_RD_ALIGN_RESP_EN
  logic res_err, out_err;
  assign out_err = state == FLUSH ? res_err : merge ? res_err | r_resp[1] : r_resp[1];
  always_ff @(posedge clk)
    if (rst) begin
      res_err <= 1'b0;
      rd_data_err <= 1'b0;
    end else begin
      if (beat && !pass) res_err <= r_resp[1];
      if (load) rd_data_err <= out_err;
    end
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      off <= '0;
      burst_q <= '0;
      size_q <= '0;
      seen <= 1'b0;
      res <= '0;
      rd_data_valid <= 1'b0;
      rd_data <= '0;
      rd_data_strb <= '0;
      rd_data_last <= 1'b0;
    end else begin
      state <= nxt;
      if (rd_cmd_valid && rd_cmd_ready) begin
        off <= rd_cmd_data_offset[OW-1:0];
        burst_q <= rd_cmd_burst;
        size_q <= rd_cmd_size;
        seen <= 1'b0;
      end
      if (beat) seen <= 1'b1;
      if (beat && !pass) res <= shifted;
      if (load) begin
        rd_data_valid <= 1'b1;
        rd_data <= out_data;
        rd_data_strb <= out_strb;
        rd_data_last <= out_last;
      end else if (rd_data_ready) rd_data_valid <= 1'b0;
    end
endmodule

// File: tb/tb_dmac_read_data_aligner.sv
// tb_dmac_read_data_aligner: directed self-checking bench for the read data aligner
module tb_dmac_read_data_aligner;
  logic clk = 0, rst = 1;
  logic rd_cmd_valid = 0, rd_cmd_ready;
  logic [1:0] rd_cmd_burst = 0;
  logic [2:0] rd_cmd_size = 3'd2;
  logic [1:0] rd_cmd_data_offset = 0;
  logic r_valid = 0, r_last = 0, r_ready;
  logic [31:0] r_data = 0;
  logic rd_data_valid, rd_data_ready = 1;
  logic [31:0] rd_data;
  logic [3:0] rd_data_strb;
  logic rd_data_last;
  logic err_obs;
`ifdef DMAC_RD_ALIGN_RESP_EN
  logic [1:0] r_resp = 0;
  logic rd_data_err;
  assign err_obs = rd_data_err;
`else
  assign err_obs = 1'b0;
`endif
  int tests = 0, fails = 0;
  typedef struct packed {logic [31:0] d; logic [3:0] s; logic l; logic e;} ob_t;
  ob_t got_q[$];

  dmac_read_data_aligner #(.ADDR_WD(32), .DATA_WD(32)) dut (
    .clk(clk), .rst(rst),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_burst(rd_cmd_burst), .rd_cmd_size(rd_cmd_size),
    .rd_cmd_data_offset(rd_cmd_data_offset),
    .r_valid(r_valid), .r_last(r_last), .r_ready(r_ready), .r_data(r_data),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
    .rd_data(rd_data), .rd_data_strb(rd_data_strb), .rd_data_last(rd_data_last)
`ifdef DMAC_RD_ALIGN_RESP_EN
    , .r_resp(r_resp), .rd_data_err(rd_data_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && rd_data_valid && rd_data_ready)
      got_q.push_back({rd_data, rd_data_strb, rd_data_last, err_obs});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] b, input logic [1:0] o);
    int n = 0;
    rd_cmd_valid = 1; rd_cmd_burst = b; rd_cmd_data_offset = o;
    do begin @(negedge clk); n++; end while (!rd_cmd_ready && n < 20);
    if (!rd_cmd_ready) check("cmd_timeout", rd_cmd_ready, 1);
    @(posedge clk); #1 rd_cmd_valid = 0;
  endtask

  task automatic rbeat(input logic [31:0] d, input logic l);
    int n = 0;
    r_valid = 1; r_data = d; r_last = l;
    do begin @(negedge clk); n++; end while (!r_ready && n < 20);
    if (!r_ready) check("beat_timeout", r_ready, 1);
    @(posedge clk); #1 r_valid = 0; r_last = 0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] d, input logic [3:0] s,
                         input logic l, input logic e);
    ob_t o;
    check({tag, "_present"}, got_q.size() != 0, 1);
    if (got_q.size() != 0) begin
      o = got_q.pop_front();
      check(tag, o, {d, s, l, e});
    end
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_cmd_ready", rd_cmd_ready, 1);
    check("rst_r_ready", r_ready, 0);
    check("rst_out", {rd_data_valid, rd_data, rd_data_strb, rd_data_last, err_obs}, 0);
    @(posedge clk); #1 r_valid = 1;
    @(negedge clk);
    check("idle_r_ready", r_ready, 0);
    @(posedge clk); #1 r_valid = 0;

    cmd(2'd1, 2'd0);
    rbeat(32'h03020100, 0);
    check("aligned_latency", {rd_data_valid, rd_data}, {1'b1, 32'h03020100});
    rbeat(32'h07060504, 0);
    rbeat(32'h0B0A0908, 0);
    rbeat(32'h0F0E0D0C, 1);
    settle();
    pop_chk("al0", 32'h03020100, 4'hF, 0, 0);
    pop_chk("al1", 32'h07060504, 4'hF, 0, 0);
    pop_chk("al2", 32'h0B0A0908, 4'hF, 0, 0);
    pop_chk("al3", 32'h0F0E0D0C, 4'hF, 1, 0);

    cmd(2'd1, 2'd1);
    rbeat(32'h03020100, 0);
    rbeat(32'h07060504, 1);
    settle();
    pop_chk("un0", 32'h04030201, 4'hF, 0, 0);
    pop_chk("un1", 32'h00070605, 4'h7, 1, 0);

    cmd(2'd1, 2'd3);
    rbeat(32'hAABBCCDD, 1);
    check("single_idle", rd_cmd_ready, 1);
    settle();
    pop_chk("single", 32'h000000AA, 4'h1, 1, 0);

    cmd(2'd0, 2'd2);
    rbeat(32'h11223344, 0);
    rbeat(32'h11223344, 0);
    rbeat(32'h11223344, 1);
    settle();
    pop_chk("fix0", 32'h00001122, 4'h3, 0, 0);
    pop_chk("fix1", 32'h00001122, 4'h3, 0, 0);
    pop_chk("fix2", 32'h00001122, 4'h3, 1, 0);

    cmd(2'd2, 2'd1);
    rbeat(32'h03020100, 0);
    rbeat(32'h07060504, 0);
    rd_data_ready = 0;
    r_valid = 1; r_data = 32'h0B0A0908; r_last = 0;
    repeat (3) begin
      @(negedge clk);
      check("bp_r_ready", r_ready, 0);
      check("bp_hold", {rd_data_valid, rd_data, rd_data_strb}, {1'b1, 32'h04030201, 4'hF});
    end
    @(posedge clk); #1 rd_data_ready = 1;
    rbeat(32'h0B0A0908, 0);
    rbeat(32'h0F0E0D0C, 1);
    settle();
    pop_chk("bp0", 32'h04030201, 4'hF, 0, 0);
    pop_chk("bp1", 32'h08070605, 4'hF, 0, 0);
    pop_chk("bp2", 32'h0C0B0A09, 4'hF, 0, 0);
    pop_chk("bp3", 32'h000F0E0D, 4'h7, 1, 0);
    check("bp_extra", got_q.size(), 0);

    cmd(2'd1, 2'd1);
    rd_data_ready = 0;
    rbeat(32'h03020100, 0);
    rbeat(32'h07060504, 0);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("mid_rst_out", {rd_data_valid, rd_data, rd_data_strb, rd_data_last, err_obs}, 0);
    check("mid_rst_ctl", {rd_cmd_ready, r_ready}, 2'b10);
    @(posedge clk); #1 rd_data_ready = 1;
    cmd(2'd1, 2'd0);
    rbeat(32'hDEADBEEF, 0);
    rbeat(32'h12345678, 1);
    settle();
    pop_chk("post_rst0", 32'hDEADBEEF, 4'hF, 0, 0);
    pop_chk("post_rst1", 32'h12345678, 4'hF, 1, 0);
    check("post_rst_extra", got_q.size(), 0);

`ifdef DMAC_RD_ALIGN_RESP_EN
    cmd(2'd1, 2'd1);
    rbeat(32'h03020100, 0);
    r_resp = 2'd2;
    rbeat(32'h07060504, 0);
    r_resp = 2'd0;
    rbeat(32'h0B0A0908, 1);
    settle();
    pop_chk("err0", 32'h04030201, 4'hF, 0, 1);
    pop_chk("err1", 32'h08070605, 4'hF, 0, 1);
    pop_chk("err2", 32'h000B0A09, 4'h7, 1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
